// File: rtl/systolic_skew_feeder_if.sv
// Handshake/data bundle between a tile source and the systolic skew feeder.
// Optional bubble_cnt signal exists only when SYSTOLIC_FEEDER_PERF_EN is defined.
interface systolic_skew_feeder_if #(
    parameter int DIN_WIDTH = 8,
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int KW        = 9
);
    logic                            start;
    logic [KW-1:0]                   k_len;
    logic                            in_valid;
    logic                            in_ready;
    logic [ROWS-1:0][DIN_WIDTH-1:0]  a_in;
    logic [COLS-1:0][DIN_WIDTH-1:0]  b_in;
    logic [ROWS-1:0][DIN_WIDTH-1:0]  a_skew;
    logic [COLS-1:0][DIN_WIDTH-1:0]  b_skew;
    logic [ROWS-1:0]                 a_vld;
    logic [COLS-1:0]                 b_vld;
    logic                            busy;
    logic                            tile_done;
`ifdef SYSTOLIC_FEEDER_PERF_EN
    logic [KW+7:0]                   bubble_cnt;
`endif

    modport master (
        output start, k_len, in_valid, a_in, b_in,
        input  in_ready, a_skew, b_skew, a_vld, b_vld, busy, tile_done
`ifdef SYSTOLIC_FEEDER_PERF_EN
        , input bubble_cnt
`endif
    );

    modport slave (
        input  start, k_len, in_valid, a_in, b_in,
        output in_ready, a_skew, b_skew, a_vld, b_vld, busy, tile_done
`ifdef SYSTOLIC_FEEDER_PERF_EN
        , output bubble_cnt
`endif
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Diagonal-skew input feeder for a ROWS x COLS output-stationary systolic array.
// Define SYSTOLIC_FEEDER_PERF_EN to add the stall counter output bubble_cnt.
module systolic_skew_feeder #(
    parameter int DIN_WIDTH = 8,
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int K_MAX     = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    systolic_skew_feeder_if.slave bus
);
    localparam int KW = $clog2(K_MAX + 1);
    localparam int F  = ROWS + COLS - 1;
    localparam int FW = $clog2(F + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]    state;
    logic [KW-1:0] k_reg;
    logic [KW-1:0] beat_cnt;
    logic [FW-1:0] flush_cnt;
    logic [KW-1:0] k_sat;
    logic          start_ok;
    logic          accept;
    logic          last_beat;
    logic          flush_end;

    assign k_sat         = (bus.k_len > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len;
    assign start_ok      = (state == S_IDLE) && bus.start && (bus.k_len != '0);
    assign bus.in_ready  = (state == S_LOAD);
    assign bus.busy      = (state != S_IDLE);
    assign accept        = bus.in_ready && bus.in_valid;
    assign last_beat     = accept && (beat_cnt == k_reg - KW'(1));
    assign flush_end     = (state == S_FLUSH) && (flush_cnt == FW'(F - 1));
    assign bus.tile_done = flush_end;

    // NOTE: all clocked state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            k_reg     <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        k_reg    <= k_sat;
                        beat_cnt <= '0;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + KW'(1);
                        if (last_beat) begin
                            flush_cnt <= '0;
                            state     <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (flush_end) state <= S_IDLE;
                    else           flush_cnt <= flush_cnt + FW'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Lane i of A is a depth-(i+1) pipe; non-accepting cycles feed zero bubbles.
    for (genvar i = 0; i < ROWS; i++) begin : g_a_lane
        logic [DIN_WIDTH-1:0] dat [0:i];
        logic                 vld [0:i];

        // NOTE: the skew pipes are reset like control state so a mid-tile reset cannot leak stale lanes.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k <= i; k++) begin
                    dat[k] <= '0;
                    vld[k] <= 1'b0;
                end
            end else begin
                dat[0] <= accept ? bus.a_in[i] : '0;
                vld[0] <= accept;
                for (int k = 1; k <= i; k++) begin
                    dat[k] <= dat[k-1];
                    vld[k] <= vld[k-1];
                end
            end
        end

        assign bus.a_skew[i] = dat[i];
        assign bus.a_vld[i]  = vld[i];
    end

    for (genvar j = 0; j < COLS; j++) begin : g_b_lane
        logic [DIN_WIDTH-1:0] dat [0:j];
        logic                 vld [0:j];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k <= j; k++) begin
                    dat[k] <= '0;
                    vld[k] <= 1'b0;
                end
            end else begin
                dat[0] <= accept ? bus.b_in[j] : '0;
                vld[0] <= accept;
                for (int k = 1; k <= j; k++) begin
                    dat[k] <= dat[k-1];
                    vld[k] <= vld[k-1];
                end
            end
        end

        assign bus.b_skew[j] = dat[j];
        assign bus.b_vld[j]  = vld[j];
    end

`ifdef SYSTOLIC_FEEDER_PERF_EN
    logic [KW+7:0] bubble_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (start_ok) begin
            bubble_cnt <= '0;
        end else if ((state == S_LOAD) && !bus.in_valid && !(&bubble_cnt)) begin
            bubble_cnt <= bubble_cnt + (KW+8)'(1);
        end
    end

    assign bus.bubble_cnt = bubble_cnt;
`endif
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: square 4x4 instance plus a 2x5 rectangular one.
module tb_systolic_skew_feeder;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    systolic_skew_feeder_if #(.DIN_WIDTH(8), .ROWS(4), .COLS(4), .KW(9)) f4 ();
    systolic_skew_feeder_if #(.DIN_WIDTH(8), .ROWS(2), .COLS(5), .KW(9)) f25 ();

    systolic_skew_feeder #(.DIN_WIDTH(8), .ROWS(4), .COLS(4), .K_MAX(256)) u_sq (
        .clk (clk),
        .rst (rst),
        .bus (f4.slave)
    );

    systolic_skew_feeder #(.DIN_WIDTH(8), .ROWS(2), .COLS(5), .K_MAX(256)) u_rect (
        .clk (clk),
        .rst (rst),
        .bus (f25.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // A lane i of beat b: lane 3 carries 1,11,21..; B lanes are negative to exercise sign bits.
    function automatic logic [7:0] va(input int b, input int lane);
        return 8'((4 - lane) + 10 * b);
    endfunction

    function automatic logic [7:0] vb(input int b, input int lane);
        return 8'(-(lane + 1) - 10 * b);
    endfunction

    task automatic drive_beat(input int b);
        f4.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            f4.a_in[i] = va(b, i);
            f4.b_in[i] = vb(b, i);
        end
    endtask

    task automatic drive_idle(input logic [7:0] junk);
        f4.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            f4.a_in[i] = junk;
            f4.b_in[i] = junk;
        end
    endtask

    // Stall tile schedule: feed slot -> beat index, -1 for a bubble.
    function automatic int stall_beat(input int slot);
        case (slot)
            0:       return 0;
            3:       return 1;
            4:       return 2;
            5:       return 3;
            default: return -1;
        endcase
    endfunction

    initial begin
        int accepts;
        int done_at;
        int bi;

        rst = 1'b1;
        f4.start = 1'b0;  f4.k_len = '0;  f4.in_valid = 1'b0;  f4.a_in = '0;  f4.b_in = '0;
        f25.start = 1'b0; f25.k_len = '0; f25.in_valid = 1'b0; f25.a_in = '0; f25.b_in = '0;
        step();
        step();

        check("rst_in_ready", f4.in_ready, 1'b0);
        check("rst_busy", f4.busy, 1'b0);
        check("rst_tile_done", f4.tile_done, 1'b0);
        check("rst_a_skew", f4.a_skew, '0);
        check("rst_b_skew", f4.b_skew, '0);
        check("rst_a_vld", f4.a_vld, '0);
        check("rst_b_vld", f4.b_vld, '0);
        check("rst_rect_busy", f25.busy, 1'b0);
        rst = 1'b0;
        step();

        // Zero-stall tile, k_len=3
        f4.start = 1'b1; f4.k_len = 9'd3;
        step();
        f4.start = 1'b0;
        check("t1_busy_s1", f4.busy, 1'b1);
        check("t1_ready_s1", f4.in_ready, 1'b1);
        for (int k = 0; k <= 10; k++) begin
            if (k < 3) drive_beat(k);
            else       drive_idle(8'h00);
            check("t1_a3", f4.a_skew[3], (k >= 4 && k <= 6) ? va(k - 4, 3) : 8'h00);
            check("t1_a3_vld", f4.a_vld[3], (k >= 4 && k <= 6));
            check("t1_a0", f4.a_skew[0], (k >= 1 && k <= 3) ? va(k - 1, 0) : 8'h00);
            check("t1_b3", f4.b_skew[3], (k >= 4 && k <= 6) ? vb(k - 4, 3) : 8'h00);
            check("t1_tile_done", f4.tile_done, (k == 9));
            check("t1_busy", f4.busy, (k <= 9));
            step();
        end
`ifdef SYSTOLIC_FEEDER_PERF_EN
        check("t1_bubble_cnt", f4.bubble_cnt, 17'd0);
`endif

        // Stalled tile, k_len=4, two bubbles after the first beat; junk on the bus while stalled
        f4.start = 1'b1; f4.k_len = 9'd4;
        step();
        f4.start = 1'b0;
        for (int k = 0; k <= 13; k++) begin
            if (stall_beat(k) >= 0 && k <= 5) drive_beat(stall_beat(k));
            else                              drive_idle(8'h55);
            for (int i = 0; i < 4; i += 3) begin
                bi = stall_beat(k - 1 - i);
                check("t2_a_dat", f4.a_skew[i], (bi >= 0) ? va(bi, i) : 8'h00);
                check("t2_a_vld", f4.a_vld[i], (bi >= 0));
                check("t2_b_dat", f4.b_skew[i], (bi >= 0) ? vb(bi, i) : 8'h00);
                check("t2_b_vld", f4.b_vld[i], (bi >= 0));
            end
            check("t2_ready", f4.in_ready, (k <= 5));
            check("t2_tile_done", f4.tile_done, (k == 12));
            step();
        end
`ifdef SYSTOLIC_FEEDER_PERF_EN
        check("t2_bubble_cnt", f4.bubble_cnt, 17'd2);
`endif

        // start with k_len=0 is ignored
        drive_idle(8'h00);
        f4.start = 1'b1; f4.k_len = 9'd0;
        step();
        f4.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("t3_zero_busy", f4.busy, 1'b0);
            check("t3_zero_done", f4.tile_done, 1'b0);
            step();
        end

        // start pulsed during LOAD with a different k_len is ignored
        f4.start = 1'b1; f4.k_len = 9'd2;
        step();
        f4.start = 1'b0;
        for (int k = 0; k <= 9; k++) begin
            if (k < 2) drive_beat(k);
            else       drive_idle(8'h00);
            f4.start = (k == 1 || k == 4);
            f4.k_len = 9'd5;
            check("t3_busy", f4.busy, (k <= 8));
            check("t3_ready", f4.in_ready, (k <= 1));
            check("t3_tile_done", f4.tile_done, (k == 8));
            step();
        end
        f4.start = 1'b0;

        // Reset two cycles into LOAD
        f4.start = 1'b1; f4.k_len = 9'd4;
        step();
        f4.start = 1'b0;
        drive_beat(0);
        step();
        drive_beat(1);
        step();
        drive_beat(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive_idle(8'h00);
        check("t4_a_skew", f4.a_skew, '0);
        check("t4_b_skew", f4.b_skew, '0);
        check("t4_a_vld", f4.a_vld, '0);
        check("t4_b_vld", f4.b_vld, '0);
        check("t4_busy", f4.busy, 1'b0);
        check("t4_ready", f4.in_ready, 1'b0);
        for (int k = 0; k < 10; k++) begin
            check("t4_no_done", f4.tile_done, 1'b0);
            check("t4_quiet_vld", f4.a_vld, '0);
            step();
        end
        f4.start = 1'b1; f4.k_len = 9'd1;
        step();
        f4.start = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            if (k == 0) drive_beat(0);
            else        drive_idle(8'h00);
            check("t4_a0", f4.a_skew[0], (k == 1) ? 8'd4 : 8'd0);
            check("t4_a3", f4.a_skew[3], (k == 4) ? 8'd1 : 8'd0);
            check("t4_tile_done", f4.tile_done, (k == 7));
            step();
        end

        // Rectangular 2x5, k_len=1
        f25.start = 1'b1; f25.k_len = 9'd1;
        step();
        f25.start = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            f25.in_valid = (k == 0);
            for (int i = 0; i < 2; i++) f25.a_in[i] = (k == 0) ? 8'(10 + i) : 8'h00;
            for (int j = 0; j < 5; j++) f25.b_in[j] = (k == 0) ? 8'(20 + j) : 8'h00;
            check("t5_b4_vld", f25.b_vld[4], (k == 5));
            check("t5_b4", f25.b_skew[4], (k == 5) ? 8'd24 : 8'd0);
            check("t5_a1_vld", f25.a_vld[1], (k == 2));
            check("t5_a1", f25.a_skew[1], (k == 2) ? 8'd11 : 8'd0);
            check("t5_tile_done", f25.tile_done, (k == 6));
            check("t5_busy", f25.busy, (k <= 6));
            step();
        end
        f25.in_valid = 1'b0;

        // Oversized k_len saturates to K_MAX=256; in_valid held high throughout
        f4.start = 1'b1; f4.k_len = 9'd300;
        step();
        f4.start = 1'b0;
        accepts = 0;
        done_at = -1;
        for (int k = 0; k < 400 && done_at < 0; k++) begin
            f4.in_valid = 1'b1;
            for (int i = 0; i < 4; i++) begin
                f4.a_in[i] = 8'(k);
                f4.b_in[i] = 8'(k);
            end
            if (f4.in_ready) accepts++;
            if (f4.tile_done) done_at = k;
            step();
        end
        check("t6_accepts", accepts, 256);
        check("t6_done_at", done_at, 262);
        check("t6_idle_after", f4.busy, 1'b0);

        // Second tile starts at L+F+1; lanes must carry only zeros until its beats arrive
        f4.start = 1'b1; f4.k_len = 9'd2;
        for (int i = 0; i < 4; i++) begin
            f4.a_in[i] = 8'h60;
            f4.b_in[i] = 8'h60;
        end
        step();
        f4.start = 1'b0;
        check("t6_busy2", f4.busy, 1'b1);
        check("t6_ready2", f4.in_ready, 1'b1);
        for (int k = 0; k <= 9; k++) begin
            f4.in_valid = (k < 2);
            for (int i = 0; i < 4; i++) begin
                f4.a_in[i] = (k < 2) ? 8'(8'h61 + k) : 8'h00;
                f4.b_in[i] = (k < 2) ? 8'(8'h71 + k) : 8'h00;
            end
            check("t6_a3", f4.a_skew[3], (k == 4) ? 8'h61 : (k == 5) ? 8'h62 : 8'h00);
            check("t6_a3_vld", f4.a_vld[3], (k == 4 || k == 5));
            check("t6_b3", f4.b_skew[3], (k == 4) ? 8'h71 : (k == 5) ? 8'h72 : 8'h00);
            check("t6_tile_done", f4.tile_done, (k == 8));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
